// File: rtl/uart_disp_pkg.sv
// rtl/uart_disp_pkg.sv - shared ASCII codes and byte class encoding for the UART display buffer
package uart_disp_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_DOT = 8'h2E;

    localparam int         NUM_DIGITS = 6;
    localparam logic [2:0] MAX_CNT    = 3'd6;

    typedef enum logic [2:0] {
        CLS_HEX   = 3'd0,
        CLS_DOT   = 3'd1,
        CLS_ENTER = 3'd2,
        CLS_BS    = 3'd3,
        CLS_ESC   = 3'd4,
        CLS_OTHER = 3'd5
    } byte_class_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// rtl/ascii_hex_decode.sv - combinational byte classifier and ASCII hex to nibble converter
module ascii_hex_decode
    import uart_disp_pkg::*;
(
    input  logic [7:0]  code,
    output byte_class_t cls,
    output logic [3:0]  nibble
);

    always_comb begin
        cls    = CLS_OTHER;
        nibble = 4'h0;
        if (code >= 8'h30 && code <= 8'h39) begin
            cls    = CLS_HEX;
            nibble = code[3:0];
        end else if ((code >= 8'h41 && code <= 8'h46) ||
                     (code >= 8'h61 && code <= 8'h66)) begin
            // 'A'..'F' and 'a'..'f' share the low nibble 1..6
            cls    = CLS_HEX;
            nibble = code[3:0] + 4'd9;
        end else begin
            case (code)
                ASCII_DOT:           cls = CLS_DOT;
                ASCII_CR, ASCII_LF:  cls = CLS_ENTER;
                ASCII_BS, ASCII_DEL: cls = CLS_BS;
                ASCII_ESC:           cls = CLS_ESC;
                default:             cls = CLS_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/uart_disp_buffer.sv
// rtl/uart_disp_buffer.sv - two-stage UART byte to six-digit edit/display buffer
module uart_disp_buffer
    import uart_disp_pkg::*;
#(
    parameter bit AUTO_COMMIT = 1'b0,
    parameter bit ECHO_ERR    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [4:0] dig0,
    output logic [4:0] dig1,
    output logic [4:0] dig2,
    output logic [4:0] dig3,
    output logic [4:0] dig4,
    output logic [4:0] dig5,
    output logic [2:0] edit_cnt,
    output logic       commit,
    output logic       err
);

    byte_class_t dec_cls;
    logic [3:0]  dec_nib;

    logic        s1_valid;
    byte_class_t s1_cls;
    logic [3:0]  s1_nib;

    logic [4:0]  edit_q [NUM_DIGITS];
    logic [4:0]  edit_d [NUM_DIGITS];
    logic [4:0]  dig_q  [NUM_DIGITS];
    logic [4:0]  dig_d  [NUM_DIGITS];
    logic [2:0]  cnt_q, cnt_d;
    logic        commit_q, commit_d;
    logic        err_q, err_d;

    ascii_hex_decode u_decode (
        .code   (rx_data),
        .cls    (dec_cls),
        .nibble (dec_nib)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_cls   <= CLS_OTHER;
            s1_nib   <= 4'h0;
        end else begin
            s1_valid <= rx_valid;
            if (rx_valid) begin
                s1_cls <= dec_cls;
                s1_nib <= dec_nib;
            end
        end
    end

    always_comb begin
        edit_d   = edit_q;
        dig_d    = dig_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        if (s1_valid) begin
            case (s1_cls)
                CLS_HEX: begin
                    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                        edit_d[i] = edit_q[i-1];
                    end
                    edit_d[0] = {1'b0, s1_nib};
                    if (cnt_q == MAX_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                    // The sixth digit commits the freshly shifted buffer directly
                    if (AUTO_COMMIT && cnt_q == MAX_CNT - 3'd1) begin
                        dig_d    = edit_d;
                        commit_d = 1'b1;
                        cnt_d    = 3'd0;
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            edit_d[i] = 5'h00;
                        end
                    end
                end
                CLS_DOT: begin
                    if (cnt_q != 3'd0) begin
                        edit_d[0][4] = 1'b1;
                    end
                end
                CLS_BS: begin
                    if (cnt_q != 3'd0) begin
                        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                            edit_d[i] = edit_q[i+1];
                        end
                        edit_d[NUM_DIGITS-1] = 5'h00;
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                CLS_ESC: begin
                    cnt_d = 3'd0;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        edit_d[i] = 5'h00;
                    end
                end
                CLS_ENTER: begin
                    // An empty buffer ignores ENTER, so CR-LF commits once
                    if (cnt_q != 3'd0) begin
                        dig_d    = edit_q;
                        commit_d = 1'b1;
                        cnt_d    = 3'd0;
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            edit_d[i] = 5'h00;
                        end
                    end
                end
                default: begin
                    err_d = ECHO_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                edit_q[i] <= 5'h00;
                dig_q[i]  <= 5'h00;
            end
            cnt_q    <= 3'd0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            edit_q   <= edit_d;
            dig_q    <= dig_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign dig0     = dig_q[0];
    assign dig1     = dig_q[1];
    assign dig2     = dig_q[2];
    assign dig3     = dig_q[3];
    assign dig4     = dig_q[4];
    assign dig5     = dig_q[5];
    assign edit_cnt = cnt_q;
    assign commit   = commit_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_disp_buffer.sv
// tb/tb_uart_disp_buffer.sv - self-checking bench for uart_disp_buffer
module tb_uart_disp_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic [4:0] dig0, dig1, dig2, dig3, dig4, dig5;
    logic [2:0] edit_cnt;
    logic       commit, err;
    logic [4:0] a_dig0, a_dig1, a_dig2, a_dig3, a_dig4, a_dig5;
    logic [2:0] a_edit_cnt;
    logic       a_commit, a_err;

    logic [29:0] m_disp, a_disp;
    assign m_disp = {dig5, dig4, dig3, dig2, dig1, dig0};
    assign a_disp = {a_dig5, a_dig4, a_dig3, a_dig2, a_dig1, a_dig0};

    always #5 clk = ~clk;

    uart_disp_buffer #(.AUTO_COMMIT(1'b0), .ECHO_ERR(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4), .dig5(dig5),
        .edit_cnt(edit_cnt), .commit(commit), .err(err)
    );

    uart_disp_buffer #(.AUTO_COMMIT(1'b1), .ECHO_ERR(1'b0)) dut_ac (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .dig0(a_dig0), .dig1(a_dig1), .dig2(a_dig2), .dig3(a_dig3), .dig4(a_dig4), .dig5(a_dig5),
        .edit_cnt(a_edit_cnt), .commit(a_commit), .err(a_err)
    );

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic [29:0] dig;
        logic [2:0]  cnt;
        logic        cm;
        logic        er;
    } vec_t;

    typedef struct {
        logic [29:0] dig;
        logic [2:0]  cnt;
        logic        cm;
        logic        er;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    int m_commit_seen = 0;
    int m_err_seen = 0;
    int a_commit_seen = 0;
    int a_err_seen = 0;

    always @(negedge clk) begin
        if (commit)   m_commit_seen++;
        if (err)      m_err_seen++;
        if (a_commit) a_commit_seen++;
        if (a_err)    a_err_seen++;
    end

    function automatic logic [29:0] d6(input logic [4:0] a5, a4, a3, a2, a1, a0);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_main(input string name, input int idx, input logic [29:0] d,
                              input logic [2:0] c, input logic cm, input logic er);
        check({name, ".disp"},   idx, {2'b0, m_disp}, {2'b0, d});
        check({name, ".cnt"},    idx, {29'b0, edit_cnt}, {29'b0, c});
        check({name, ".commit"}, idx, {31'b0, commit}, {31'b0, cm});
        check({name, ".err"},    idx, {31'b0, err}, {31'b0, er});
    endtask

    task automatic add(input logic v, input logic [7:0] b, input logic [29:0] d,
                       input logic [2:0] c, input logic cm, input logic er);
        vec_t t;
        t.v = v; t.b = b; t.dig = d; t.cnt = c; t.cm = cm; t.er = er;
        vecs.push_back(t);
    endtask

    // Each vector occupies one cycle; its results are due two edges after it is driven.
    task automatic run_vectors();
        exp_t e;
        int   nv;
        nv = vecs.size();
        for (int n = 0; n < nv + 2; n++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].idx == n - 2) begin
                e = sb.pop_front();
                check_main("vec", e.idx, e.dig, e.cnt, e.cm, e.er);
            end
            if (n < nv) begin
                rx_valid = vecs[n].v;
                rx_data  = vecs[n].b;
                e.dig = vecs[n].dig; e.cnt = vecs[n].cnt; e.cm = vecs[n].cm;
                e.er = vecs[n].er; e.idx = n;
                sb.push_back(e);
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'h00;
            end
        end
        check("sb_drained", 0, sb.size(), 0);
        vecs.delete();
    endtask

    logic [29:0] da, db, dc, dd, de;
    int snap_mc, snap_me, snap_ac, snap_ae;

    initial begin
        da = d6(5'h00, 5'h01, 5'h12, 5'h03, 5'h0A, 5'h0B);
        db = d6(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h07);
        dc = d6(5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07);
        dd = d6(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0D);
        de = d6(5'h0F, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A);

        repeat (2) @(negedge clk);
        check_main("reset", 0, 30'h0, 3'd0, 1'b0, 1'b0);
        check("reset.a_disp", 0, {2'b0, a_disp}, 32'h0);
        rst = 1'b1;

        // Basic entry "12.3aB" CR
        add(1, "1", 30'h0, 3'd1, 0, 0);
        add(1, "2", 30'h0, 3'd2, 0, 0);
        add(1, ".", 30'h0, 3'd2, 0, 0);
        add(1, "3", 30'h0, 3'd3, 0, 0);
        add(1, "a", 30'h0, 3'd4, 0, 0);
        add(1, "B", 30'h0, 3'd5, 0, 0);
        add(1, 8'h0D, da, 3'd0, 1, 0);
        add(0, 8'h00, da, 3'd0, 0, 0);
        // CR-LF commits once
        add(1, "7", da, 3'd1, 0, 0);
        add(1, 8'h0D, db, 3'd0, 1, 0);
        add(1, 8'h0A, db, 3'd0, 0, 0);
        add(0, 8'h00, db, 3'd0, 0, 0);
        // Overflow "1234567" CR
        for (int i = 1; i <= 6; i++) add(1, 8'(8'h30 + i), db, 3'(i), 0, 0);
        add(1, "7", db, 3'd6, 0, 1);
        add(1, 8'h0D, dc, 3'd0, 1, 0);
        add(0, 8'h00, dc, 3'd0, 0, 0);
        // Editing, empty-buffer BS/DOT, OTHER
        add(1, 8'h08, dc, 3'd0, 0, 0);
        add(1, ".", dc, 3'd0, 0, 0);
        add(1, "A", dc, 3'd1, 0, 0);
        add(1, "B", dc, 3'd2, 0, 0);
        add(1, 8'h7F, dc, 3'd1, 0, 0);
        add(1, "C", dc, 3'd2, 0, 0);
        add(1, 8'h1B, dc, 3'd0, 0, 0);
        add(1, "D", dc, 3'd1, 0, 0);
        add(1, 8'h0D, dd, 3'd0, 1, 0);
        add(1, "x", dd, 3'd0, 0, 1);
        add(0, 8'h00, dd, 3'd0, 0, 0);
        // Back-to-back "FEDCBA" CR 'G'
        add(1, "F", dd, 3'd1, 0, 0);
        add(1, "E", dd, 3'd2, 0, 0);
        add(1, "D", dd, 3'd3, 0, 0);
        add(1, "C", dd, 3'd4, 0, 0);
        add(1, "B", dd, 3'd5, 0, 0);
        add(1, "A", dd, 3'd6, 0, 0);
        add(1, 8'h0D, de, 3'd0, 1, 0);
        add(1, "G", de, 3'd0, 0, 1);
        add(0, 8'h00, de, 3'd0, 0, 0);
        run_vectors();

        // Reset asserted while CR sits in stage 1
        @(negedge clk); rx_valid = 1'b1; rx_data = "1";
        @(negedge clk); rx_data = "2";
        @(negedge clk); rx_data = "3";
        @(negedge clk); rx_data = 8'h0D; snap_mc = m_commit_seen;
        @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
        check("rst_mid.cnt_before", 0, {29'b0, edit_cnt}, 32'd3);
        rst = 1'b0;
        @(negedge clk);
        check_main("rst_mid", 0, 30'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_main("rst_mid", 1, 30'h0, 3'd0, 1'b0, 1'b0);
        check("rst_mid.no_commit", 0, m_commit_seen - snap_mc, 0);
        rst = 1'b1; rx_valid = 1'b1; rx_data = "5";
        @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        check_main("rst_release", 0, 30'h0, 3'd1, 1'b0, 1'b0);
        check("rst_release.a_cnt", 0, {29'b0, a_edit_cnt}, 32'd1);

        // Auto-commit on the sixth digit; ECHO_ERR=0 instance drops 'x' silently
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_main("reset2", 0, 30'h0, 3'd0, 1'b0, 1'b0);
        check("reset2.a_cnt", 0, {29'b0, a_edit_cnt}, 32'd0);
        rst = 1'b1;
        snap_mc = m_commit_seen; snap_me = m_err_seen;
        snap_ac = a_commit_seen; snap_ae = a_err_seen;
        @(negedge clk); rx_valid = 1'b1; rx_data = "x";
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); rx_data = 8'(8'h30 + i);
        end
        @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        check("auto.a_commit", 0, {31'b0, a_commit}, 32'd1);
        check("auto.a_disp", 0, {2'b0, a_disp},
              {2'b0, d6(5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06)});
        check("auto.a_cnt", 0, {29'b0, a_edit_cnt}, 32'd0);
        check_main("auto.main", 0, 30'h0, 3'd6, 1'b0, 1'b0);
        @(negedge clk);
        check("auto.a_commit_end", 0, {31'b0, a_commit}, 32'd0);
        repeat (2) @(negedge clk);
        check("auto.a_commit_count", 0, a_commit_seen - snap_ac, 1);
        check("auto.a_err_count", 0, a_err_seen - snap_ae, 0);
        check("auto.m_err_count", 0, m_err_seen - snap_me, 1);
        check("auto.m_commit_count", 0, m_commit_seen - snap_mc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_disp_buffer.md
UART_DISP_BUFFER -- requirements
Module: uart_disp_buffer

Interface
REQ-001 SHALL have parameter AUTO_COMMIT, default 0, meaning 1 = commit automatically when the 6th digit is entered.
REQ-002 SHALL have parameter ECHO_ERR, default 1, meaning 1 = err pulses on unrecognised bytes, 0 = unrecognised bytes are silently dropped.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have ports dig0..dig5  output  5 each  displayed digits; [3:0] hex value, [4] decimal point active-high; dig0 is rightmost; feed the 7-seg mux in0..in5.
REQ-008 SHALL have port edit_cnt  output  3  number of digits held in the edit buffer, 0..6.
REQ-009 SHALL have port commit  output  1  one-cycle pulse when the display registers load.
REQ-010 SHALL have port err  output  1  one-cycle pulse on an unrecognised byte, or on a digit dropped by overflow.

Function
REQ-011 SHALL classify bytes as: HEX ('0'-'9', 'A'-'F', 'a'-'f'); DOT (0x2E); ENTER (0x0D or 0x0A); BS (0x08 or 0x7F); ESC (0x1B); OTHER.
REQ-012 SHALL use two pipeline stages: stage 1 registers the class and nibble on rx_valid; stage 2 updates the edit buffer and display on the next edge.
REQ-013 SHALL make all results (dig*, edit_cnt, commit, err) visible exactly 2 clk edges after the edge that sampled rx_valid=1.
REQ-014 SHALL accept rx_valid on consecutive cycles without loss, with every byte processed in order.
REQ-015 SHALL, on HEX, shift edit[i] into edit[i+1] for i=0..4 and load edit[0] = {1'b0, nibble}; edit_cnt increments and saturates at 6.
REQ-016 SHALL, on HEX with edit_cnt==6 and AUTO_COMMIT=0, still shift, discard the old edit[5], and pulse err.
REQ-017 SHALL, on HEX with AUTO_COMMIT=1 taking edit_cnt from 5 to 6, commit in the same stage-2 cycle using the post-shift buffer.
REQ-018 SHALL, on DOT, set edit[0][4]; with edit_cnt==0 the byte is ignored, no err pulse.
REQ-019 SHALL, on BS, shift edit[i+1] into edit[i], set edit[5] = 0 and decrement edit_cnt; with edit_cnt==0 there is no change.
REQ-020 SHALL, on ESC, clear the edit buffer to all zero and set edit_cnt = 0; the display is unchanged.
REQ-021 SHALL, on ENTER with edit_cnt>0, set dig[i] = edit[i], clear edit, set edit_cnt = 0 and pulse commit.
REQ-022 SHALL, on ENTER with edit_cnt==0, take no action, so that a CR-LF pair commits only once.
REQ-023 SHALL, on OTHER, leave state unchanged and pulse err when ECHO_ERR=1.
REQ-024 SHALL treat the unused upper digits of an uncommitted partial entry as 0 when the entry is committed (e.g. "1F" displays 00001F).
REQ-025 SHALL hold the dig* outputs stable between commits; each output is driven directly from a register.

Reset
REQ-026 SHALL, on rst=0, asynchronously clear dig0..dig5 to 5'b00000, the edit buffer to zero, edit_cnt to 0, commit and err to 0, and the stage-1 valid flag to 0.
REQ-027 SHALL discard any byte held in stage 1 when reset asserts mid-pipeline.
REQ-028 SHALL sample the first byte after reset release on the first clk edge with rst=1.

Structure
REQ-029 SHALL place the ASCII codes (0x0D, 0x0A, 0x08, 0x7F, 0x1B, 0x2E) and the 3-bit class encoding (HEX, DOT, ENTER, BS, ESC, OTHER) in shared package uart_disp_pkg.
REQ-030 SHALL implement byte classification and ASCII-to-nibble conversion in a combinational sub-module ascii_hex_decode (in: 8-bit byte; out: class, nibble).
REQ-031 SHALL keep the edit buffer and display registers as separate 6x5-bit arrays in uart_disp_buffer.

Verification
REQ-032 SHALL verify basic entry: bytes "12.3aB" then 0x0D -> dig5..dig0 = 1, 2+dp, 3, A, B, then the last slot holds B; precisely, digits 1, 2, 3, A, B plus DOT yields dig4..dig0 = 01,12,03,0A,0B and dig5 = 00; commit pulses once, exactly 2 edges after the CR.
REQ-033 SHALL verify CR-LF: bytes "7", 0x0D, 0x0A -> exactly one commit pulse, dig0 = 5'h07.
REQ-034 SHALL verify overflow: bytes "1234567" then CR with AUTO_COMMIT=0 -> one err pulse on '7', display 234567, edit_cnt returns to 0.
REQ-035 SHALL verify editing: bytes "AB", BS, "C", ESC, "D", CR -> display 00000D; a BS at edit_cnt==0 leaves state unchanged.
REQ-036 SHALL verify back-to-back input: rx_valid held high for 8 consecutive cycles carrying "FEDCBA", 0x0D, 'G' -> display FEDCBA, then one err pulse for 'G'.
REQ-037 SHALL verify reset mid-operation: assert rst on the cycle after rx_valid with 0x0D and edit_cnt=3 -> no commit, all outputs 0; AUTO_COMMIT=1 with "123456" -> commit pulses on '6' with no ENTER needed.
